// File: rtl/seg7_bcd_display.sv
// seg7_bcd_display: sequential binary-to-BCD converter driving DIGITS active-low
// seven-segment displays with leading-zero blanking, minus sign and overflow.
module seg7_bcd_display #(
    parameter int WIDTH    = 12,
    parameter int DIGITS   = 6,
    parameter int SIGNED   = 1,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_value,
    output logic                  in_ready,
    output logic                  done,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   display
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

    state_t              state_q, state_d;
    logic [WIDTH:0]      ext, mag_q, mag_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d, corr;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                sign_q, sign_d, ovf_q, ovf_d, ovf_all, last, seen, overflow_q;
    logic [7*DIGITS-1:0] disp_q, disp_d;
    logic [DIGITS-1:0]   shown;
    logic [DIGITS:0]     below;

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h18;
            default: seg = 7'h7F;
        endcase
    endfunction

    assign last = state_q == CONVERT && cnt_q == CW'(WIDTH);

    always_ff @(posedge clk) begin
        state_q <= rst ? IDLE : state_d;
    end

    always_comb begin
        state_d = state_q == IDLE    ? (in_valid && in_ready ? CONVERT : IDLE) :
                  state_q == CONVERT ? (last ? LOAD : CONVERT) : IDLE;
    end

    always_comb begin
        in_ready = state_q == IDLE && !rst;
        done     = state_q == LOAD;
        overflow = overflow_q;
        display  = disp_q;
    end

    // One extra magnitude bit so the most negative input negates without wrapping
    always_comb begin
        ext    = {SIGNED != 0 && in_value[WIDTH-1], in_value};
        mag_d  = mag_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        sign_d = sign_q;
        ovf_d  = ovf_q;
        for (int i = 0; i < DIGITS; i++)
            corr[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
        if (state_q == IDLE && in_valid && in_ready) begin
            sign_d = ext[WIDTH];
            mag_d  = ext[WIDTH] ? -ext : ext;
            bcd_d  = '0;
            cnt_d  = '0;
            ovf_d  = 1'b0;
        end else if (state_q == CONVERT) begin
            bcd_d = {corr[4*DIGITS-2:0], mag_q[WIDTH]};
            mag_d = mag_q << 1;
            cnt_d = cnt_q + 1'b1;
            ovf_d = ovf_q | corr[4*DIGITS-1];
        end
    end

    // A negative result needs its top position free for the minus sign
    always_comb begin
        ovf_all = ovf_d | (sign_q && bcd_d[4*DIGITS-1 -: 4] != 4'd0);
        seen    = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen     = seen | bcd_d[4*i +: 4] != 4'd0 | i == 0 | BLANK_LZ == 0;
            shown[i] = seen;
        end
        below  = {shown, 1'b0};
        disp_d = '0;
        for (int j = 0; j < DIGITS; j++)
            disp_d[7*j +: 7] = ovf_all ? 7'h3F :
                (sign_q && (BLANK_LZ != 0 ? below[j] && !shown[j] : j == DIGITS - 1)) ? 7'h3F :
                shown[j] ? seg(bcd_d[4*j +: 4]) : 7'h7F;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mag_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            ovf_q      <= 1'b0;
            disp_q     <= '1;
            overflow_q <= 1'b0;
        end else begin
            mag_q      <= mag_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            ovf_q      <= ovf_d;
            disp_q     <= last ? disp_d : disp_q;
            overflow_q <= last ? ovf_all : overflow_q;
        end
    end
endmodule

// File: tb/tb_seg7_bcd_display.sv
// tb_seg7_bcd_display: checks three configurations (6 digits blanked, 3 digits,
// 6 digits unblanked) against an arithmetic decimal model, plus protocol corners.
module tb_seg7_bcd_display;
    logic        clk, rst, in_valid;
    logic [11:0] in_value;
    logic        rdy0, rdy3, rdyb, done0, done3, doneb, ov0, ov3, ovb;
    logic [41:0] d0, db;
    logic [20:0] d3;
    logic [41:0] prev0;
    logic [6:0]  seg_tab [10];
    int          n_chk = 0, n_pass = 0;

    typedef struct {
        logic [11:0] v;
        int          sel;
        logic [41:0] disp;
        logic        ovf;
    } vec_t;
    vec_t tv [9];

    seg7_bcd_display #(.WIDTH(12), .DIGITS(6), .SIGNED(1), .BLANK_LZ(1)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_value(in_value),
        .in_ready(rdy0), .done(done0), .overflow(ov0), .display(d0));
    seg7_bcd_display #(.WIDTH(12), .DIGITS(3), .SIGNED(1), .BLANK_LZ(1)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_value(in_value),
        .in_ready(rdy3), .done(done3), .overflow(ov3), .display(d3));
    seg7_bcd_display #(.WIDTH(12), .DIGITS(6), .SIGNED(1), .BLANK_LZ(0)) ub (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_value(in_value),
        .in_ready(rdyb), .done(doneb), .overflow(ovb), .display(db));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string n, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", n, got, exp);
    endtask

    // Decimal digits by division; minus and blanking decided from digit count
    function automatic void model(input int v, input int d, input int blz,
                                  output logic [55:0] disp, output logic ovf);
        longint m = v < 0 ? -v : v;
        longint p = 1, t;
        int     nd = 1;
        bit     neg = v < 0;
        for (int i = 0; i < d; i++) p *= 10;
        ovf = m >= p || (neg && m * 10 >= p);
        for (t = m; t >= 10; t /= 10) nd++;
        disp = '0;
        t = m;
        for (int i = 0; i < d; i++) begin
            if (ovf) disp[7*i +: 7] = 7'h3F;
            else if (neg && (blz != 0 ? i == nd : i == d - 1)) disp[7*i +: 7] = 7'h3F;
            else if (blz != 0 && i >= nd) disp[7*i +: 7] = 7'h7F;
            else disp[7*i +: 7] = seg_tab[int'(t % 10)];
            t /= 10;
        end
    endfunction

    task automatic send(input logic [11:0] x, input bit hold);
        int          lat, w = 0;
        logic [55:0] e0, e3, eb;
        logic        o0, o3, ob;
        while (!rdy0 && w < 50) begin @(posedge clk); #1; w++; end
        check("ready_wait", rdy0, 1);
        @(negedge clk);
        in_valid = 1'b1;
        in_value = x;
        @(posedge clk); #1;
        lat = 1;
        if (hold) in_value = 12'h000;
        else in_valid = 1'b0;
        while (!done0 && lat < 40) begin
            if (lat == 6) begin
                check("busy_ready", rdy0, 0);
                check("hold_display", d0, prev0);
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        check("latency", lat, 14);
        model(int'($signed(x)), 6, 1, e0, o0);
        model(int'($signed(x)), 3, 1, e3, o3);
        model(int'($signed(x)), 6, 0, eb, ob);
        check("disp6", d0, e0);
        check("ovf6", ov0, o0);
        check("disp3", d3, e3);
        check("ovf3", ov3, o3);
        check("disp6_nolz", db, eb);
        check("ovf6_nolz", ovb, ob);
        prev0 = e0[41:0];
        @(posedge clk); #1;
        check("done_pulse", done0, 0);
        check("ready_after", rdy0, 1);
    endtask

    initial begin
        logic [63:0] gd;
        logic        go;
        int          pulses;
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h18};
        tv[0] = '{12'd1234, 0, {7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19}, 1'b0};
        tv[1] = '{12'd0,    0, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b0};
        tv[2] = '{12'hFFB,  0, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F, 7'h12}, 1'b0};
        tv[3] = '{12'h800,  0, {7'h7F, 7'h3F, 7'h24, 7'h40, 7'h19, 7'h00}, 1'b0};
        tv[4] = '{12'd999,  1, {21'h0, 7'h18, 7'h18, 7'h18}, 1'b0};
        tv[5] = '{12'd1000, 1, {21'h0, 7'h3F, 7'h3F, 7'h3F}, 1'b1};
        tv[6] = '{12'hF9D,  1, {21'h0, 7'h3F, 7'h18, 7'h18}, 1'b0};
        tv[7] = '{12'hF9C,  1, {21'h0, 7'h3F, 7'h3F, 7'h3F}, 1'b1};
        tv[8] = '{12'd7,    2, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h78}, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0;
        in_value = '0;
        prev0 = '1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_disp6", d0, {42{1'b1}});
        check("rst_disp3", d3, {21{1'b1}});
        check("rst_done", done0, 0);
        check("rst_ovf", ov0, 0);
        check("rst_ready", rdy0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_idle", rdy0, 1);

        for (int k = 0; k < 9; k++) begin
            send(tv[k].v, 1'b0);
            gd = tv[k].sel == 0 ? 64'(d0) : tv[k].sel == 1 ? 64'(d3) : 64'(db);
            go = tv[k].sel == 0 ? ov0 : tv[k].sel == 1 ? ov3 : ovb;
            check($sformatf("vec%0d_disp", k), gd, 64'(tv[k].disp));
            check($sformatf("vec%0d_ovf", k), go, tv[k].ovf);
        end

        send(12'd1234, 1'b1);
        send(12'h7FF, 1'b0);
        send(12'h801, 1'b0);
        for (int k = 0; k < 40; k++) send(12'($urandom_range(0, 4095)), 1'b0);

        @(negedge clk);
        in_valid = 1'b1;
        in_value = 12'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_disp6", d0, {42{1'b1}});
        check("midrst_disp3", d3, {21{1'b1}});
        check("midrst_done", done0, 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done0) pulses++;
        end
        check("midrst_no_done", pulses, 0);
        check("midrst_hold", d0, {42{1'b1}});
        prev0 = '1;
        send(12'hFFB, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/seg7_bcd_display.md
Name: seg7_bcd_display

Overview:
- Parametrised successor to the single-digit 4-bit seven-segment decoder.
- Accepts a signed or unsigned binary value through a valid/ready handshake and converts it to BCD sequentially (shift-add-3, one bit per clock).
- Drives DIGITS active-low seven-segment displays with leading-zero blanking, a minus sign and overflow indication.
- Sits between the accelerometer axis datapath and the board HEX displays.

Parameters:
- WIDTH, 12, width of in_value in bits (2..32).
- DIGITS, 6, number of seven-segment digits driven (1..8).
- SIGNED, 1, 1 = in_value is two's complement; 0 = unsigned.
- BLANK_LZ, 1, 1 = blank leading zeros; 0 = show all digits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_value is valid this cycle.
- in_value  input  WIDTH  binary value to display.
- in_ready  output  1  block can accept a value; high only in IDLE with rst low.
- done  output  1  one-cycle pulse when display is updated.
- overflow  output  1  last accepted value did not fit in DIGITS positions.
- display  output  7*DIGITS  segments, active low; bits [6:0] = digit 0 (least significant); bit0 = a … bit6 = g.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Segment codes (hex, active low):
  - Digits 0–9: 40, 79, 24, 30, 19, 12, 02, 78, 00, 18.
  - Blank: 7F.
  - Minus: 3F (segment g only).
- Reset: state IDLE, display all 7F, done 0, overflow 0, internal shift/BCD registers cleared.
- Reset mid-conversion aborts the conversion; no done pulse is issued.
- FSM has three states: IDLE, CONVERT, LOAD.
- IDLE:
  - On in_valid && in_ready, capture sign (SIGNED && in_value MSB) and magnitude.
  - Magnitude is WIDTH+1 bits so the most negative value converts correctly.
  - Clear BCD register and iteration counter, then go to CONVERT. in_valid in other states is ignored.
- CONVERT:
  - Each cycle, add 3 to every BCD nibble ≥ 5, then shift {bcd, magnitude} left by one.
  - Exactly WIDTH+1 iterations, then go to LOAD.
  - A 1 shifted out of the top BCD nibble sets a sticky overflow flag.
- LOAD:
  - Register the display and overflow outputs, pulse done for one cycle, return to IDLE.
  - in_ready is high again on the cycle after done.
- Latency: handshake edge to display update is WIDTH+2 rising edges. display holds its previous value throughout conversion.
- Overflow:
  - Set when magnitude ≥ 10^DIGITS.
  - For a negative value, also set when magnitude ≥ 10^(DIGITS-1), since the sign needs one position.
  - On overflow, every digit shows 3F.
- Blanking with BLANK_LZ=1:
  - Digits above the most significant nonzero digit show 7F.
  - Digit 0 is always shown, so value 0 displays "0".
  - Minus occupies the position immediately left of the most significant shown digit.
- Blanking with BLANK_LZ=0:
  - All digits are shown, including leading zeros.
  - Minus replaces digit DIGITS-1; overflow then applies the signed rule above.
- SIGNED=0: the sign is always 0 and no minus is ever shown.
- Back-to-back operation: a new value can be accepted on the cycle after done. Maximum throughput is one value per WIDTH+3 cycles.

Test Plan:
- Reset, defaults -> display = all 7F, done=0, overflow=0; in_ready=1 after the first clock with rst low.
- in_value=1234 -> after 14 edges, done pulses once:
  - digit0=19, digit1=30, digit2=24, digit3=79, digits4–5=7F; overflow=0.
- in_value=0 -> digit0=40, others 7F.
- in_value=12'hFFB (-5) -> digit0=12, digit1=3F, rest 7F.
- in_value=12'h800 (-2048) -> digits0–3 = 00, 19, 40, 24; digit4=3F; digit5=7F.
- DIGITS=3 configuration:
  - 999 -> 18, 18, 18, overflow=0.
  - 1000 -> 3F, 3F, 3F, overflow=1.
  - -99 -> 18, 18, 3F.
  - -100 -> 3F, 3F, 3F, overflow=1.
- Protocol checks:
  - in_valid held during CONVERT -> ignored, in_ready=0, result unchanged.
  - rst asserted mid-CONVERT -> display=all 7F next cycle, no done pulse.
  - BLANK_LZ=0 with value 7 -> 78, 40, 40, 40, 40, 40.
